// File: rtl/time_set_fsm.sv
// 24-hour time-setting controller: set/up/down buttons edit a copy of the live time,
// with auto-repeat on held buttons and an inactivity timeout that abandons the edit.
module time_set_fsm #(
    parameter int HAS_SECONDS   = 1,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10,
    parameter int TIMEOUT       = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set,
    input  logic       up,
    input  logic       down,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    input  logic [5:0] cur_seconds,
    output logic       propagate,
    output logic       aborted,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] current_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOUR   = 2'd1,
        MINUTE = 2'd2,
        SECOND = 2'd3
    } state_e;

    localparam logic [15:0] DELAY_C    = 16'(REPEAT_DELAY);
    localparam logic [15:0] RELOAD_C   = 16'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    localparam logic [15:0] TMO_C      = 16'(TIMEOUT);
    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
    localparam bit          SECONDS_EN = (HAS_SECONDS != 0);

    state_e      state_q;
    logic [4:0]  hours_q;
    logic [5:0]  minutes_q;
    logic [5:0]  seconds_q;
    logic        propagate_q;
    logic        aborted_q;

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]  btn;
    logic [1:0]  btn_q;
    logic [1:0]  rise;
    logic [1:0]  fire;
    logic [1:0]  act_q;
    logic [1:0]  act_d;
    logic [15:0] cnt_q [2];
    logic [15:0] cnt_d [2];

    logic [15:0] to_q;
    logic [15:0] to_d;
    logic        ph_q;
    logic        ph_d;

    logic        edit;
    logic        hold_ok;
    logic        activity;
    logic        to_inc;
    logic        timeout_hit;

    function automatic logic [4:0] step_hours(input logic [4:0] v, input logic inc);
        if (inc) return (v == 5'd23) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    function automatic logic [5:0] step_sixty(input logic [5:0] v, input logic inc);
        if (inc) return (v == 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    always_comb begin
        btn     = {down, up};
        edit    = (state_q != IDLE);
        rise    = btn & ~btn_q;
        // A set, or both buttons together, discards any step and disarms repeat.
        hold_ok = edit && !set && !(up && down);
        for (int i = 0; i < 2; i++) begin
            fire[i]  = hold_ok && (rise[i] || (btn[i] && act_q[i] && cnt_q[i] == DELAY_C));
            act_d[i] = act_q[i];
            cnt_d[i] = cnt_q[i];
            if (!hold_ok || !btn[i]) begin
                act_d[i] = 1'b0;
                cnt_d[i] = 16'd0;
            end else if (rise[i]) begin
                act_d[i] = 1'b1;
                cnt_d[i] = 16'd1;
            end else if (act_q[i]) begin
                cnt_d[i] = (cnt_q[i] == DELAY_C) ? RELOAD_C : cnt_q[i] + 16'd1;
            end
        end

        activity    = edit && (set || (|rise) || (|fire));
        to_inc      = TIMEOUT_EN && edit && !activity && ph_q;
        timeout_hit = to_inc && (to_q == TMO_C - 16'd1);

        to_d = to_q;
        ph_d = ph_q;
        if (!edit || activity) begin
            to_d = 16'd0;
            ph_d = 1'b0;
        end else begin
            ph_d = !ph_q;
            if (to_inc) to_d = to_q + 16'd1;
        end
    end

    // NOTE: every register here updates with <= so all of them see the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hours_q     <= 5'd0;
            minutes_q   <= 6'd0;
            seconds_q   <= 6'd0;
            propagate_q <= 1'b0;
            aborted_q   <= 1'b0;
            btn_q       <= 2'b00;
            act_q       <= 2'b00;
            cnt_q[0]    <= 16'd0;
            cnt_q[1]    <= 16'd0;
            to_q        <= 16'd0;
            ph_q        <= 1'b0;
        end else begin
            btn_q       <= btn;
            act_q       <= act_d;
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            to_q        <= to_d;
            ph_q        <= ph_d;
            propagate_q <= 1'b0;
            aborted_q   <= 1'b0;

            if (timeout_hit) begin
                state_q   <= IDLE;
                aborted_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (set) begin
                            state_q   <= HOUR;
                            hours_q   <= (cur_hours > 5'd23) ? 5'd0 : cur_hours;
                            minutes_q <= (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
                            seconds_q <= (SECONDS_EN && cur_seconds <= 6'd59) ? cur_seconds : 6'd0;
                        end
                    end
                    HOUR: begin
                        if (set) state_q <= MINUTE;
                        else if (|fire) hours_q <= step_hours(hours_q, fire[0]);
                    end
                    MINUTE: begin
                        if (set) begin
                            if (SECONDS_EN) begin
                                state_q <= SECOND;
                            end else begin
                                state_q     <= IDLE;
                                propagate_q <= 1'b1;
                            end
                        end else if (|fire) begin
                            minutes_q <= step_sixty(minutes_q, fire[0]);
                        end
                    end
                    SECOND: begin
                        if (set) begin
                            state_q     <= IDLE;
                            propagate_q <= 1'b1;
                        end else if (|fire) begin
                            seconds_q <= step_sixty(seconds_q, fire[0]);
                        end
                    end
                endcase
            end
        end
    end

    assign propagate     = propagate_q;
    assign aborted       = aborted_q;
    assign hours         = hours_q;
    assign minutes       = minutes_q;
    assign seconds       = seconds_q;
    assign current_state = state_q;

endmodule

// File: tb/tb_time_set_fsm.sv
// Directed bench for time_set_fsm: expectations are queued with each stimulus step
// and popped for comparison once the clock edge has produced the DUT's response.
module tb_time_set_fsm;

    localparam int D = 4;
    localparam int P = 2;
    localparam int T = 20;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOUR   = 2'd1;
    localparam logic [1:0] S_MINUTE = 2'd2;
    localparam logic [1:0] S_SECOND = 2'd3;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       p;
        logic       a;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       set;
    logic       up;
    logic       down;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [5:0] cur_seconds;

    logic       dut_prop, dut_abrt;
    logic [4:0] dut_h;
    logic [5:0] dut_m, dut_s;
    logic [1:0] dut_st;

    logic       ns_prop, ns_abrt;
    logic [4:0] ns_h;
    logic [5:0] ns_m, ns_s;
    logic [1:0] ns_st;

    int   checks = 0;
    int   errors = 0;
    int   m_exp;
    exp_t sb_q[$];

    time_set_fsm #(
        .HAS_SECONDS(1), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .TIMEOUT(T)
    ) u_dut (
        .clk(clk), .reset(reset), .set(set), .up(up), .down(down),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .propagate(dut_prop), .aborted(dut_abrt),
        .hours(dut_h), .minutes(dut_m), .seconds(dut_s),
        .current_state(dut_st)
    );

    time_set_fsm #(
        .HAS_SECONDS(0), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .TIMEOUT(T)
    ) u_dut_ns (
        .clk(clk), .reset(reset), .set(set), .up(up), .down(down),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .propagate(ns_prop), .aborted(ns_abrt),
        .hours(ns_h), .minutes(ns_m), .seconds(ns_s),
        .current_state(ns_st)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] st, input logic [4:0] h,
                        input logic [5:0] m, input logic [5:0] s, input logic p, input logic a);
        exp_t e;
        e.tag = tag; e.st = st; e.h = h; e.m = m; e.s = s; e.p = p; e.a = a;
        sb_q.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check({e.tag, ".state"},     32'(dut_st),   32'(e.st));
        check({e.tag, ".hours"},     32'(dut_h),    32'(e.h));
        check({e.tag, ".minutes"},   32'(dut_m),    32'(e.m));
        check({e.tag, ".seconds"},   32'(dut_s),    32'(e.s));
        check({e.tag, ".propagate"}, 32'(dut_prop), 32'(e.p));
        check({e.tag, ".aborted"},   32'(dut_abrt), 32'(e.a));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [1:0] st, input logic [4:0] h,
                       input logic [5:0] m, input logic [5:0] s, input logic p, input logic a);
        push(tag, st, h, m, s, p, a);
        tick();
        pop_compare();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; set = 1'b0; up = 1'b0; down = 1'b0;
        cur_hours = 5'd13; cur_minutes = 6'd45; cur_seconds = 6'd30;

        // Reset state, observed before any clock edge
        #2;
        push("reset", S_IDLE, 0, 0, 0, 0, 0);
        pop_compare();
        check("ns_reset.state", 32'(ns_st), 32'(S_IDLE));
        tick();
        reset = 1'b1;

        // Buttons are ignored in IDLE
        up = 1'b1;
        cyc("idle_up", S_IDLE, 0, 0, 0, 0, 0);
        up = 1'b0;
        cyc("idle_rel", S_IDLE, 0, 0, 0, 0, 0);

        // Preload from live time, then commit with no edits
        set = 1'b1;
        cyc("preload", S_HOUR, 13, 45, 30, 0, 0);
        check("ns_preload.state", 32'(ns_st), 32'(S_HOUR));
        cyc("to_minute", S_MINUTE, 13, 45, 30, 0, 0);
        check("ns_to_minute.state", 32'(ns_st), 32'(S_MINUTE));
        cyc("to_second", S_SECOND, 13, 45, 30, 0, 0);
        check("ns_commit.propagate", 32'(ns_prop), 32'd1);
        check("ns_commit.state",     32'(ns_st),   32'(S_IDLE));
        check("ns_commit.hours",     32'(ns_h),    32'd13);
        check("ns_commit.minutes",   32'(ns_m),    32'd45);
        check("ns_commit.seconds",   32'(ns_s),    32'd0);
        cyc("commit", S_IDLE, 13, 45, 30, 1, 0);
        check("ns_after.propagate", 32'(ns_prop), 32'd0);
        set = 1'b0;
        cyc("commit_end", S_IDLE, 13, 45, 30, 0, 0);

        // Wrap-around in every field, no carry between fields
        cur_hours = 5'd23; cur_minutes = 6'd0; cur_seconds = 6'd59;
        set = 1'b1;
        cyc("w_load", S_HOUR, 23, 0, 59, 0, 0);
        set = 1'b0;
        up = 1'b1;
        cyc("w_h_up", S_HOUR, 0, 0, 59, 0, 0);
        up = 1'b0;
        cyc("w_h_rel", S_HOUR, 0, 0, 59, 0, 0);
        down = 1'b1;
        cyc("w_h_dn", S_HOUR, 23, 0, 59, 0, 0);
        down = 1'b0;
        cyc("w_h_rel2", S_HOUR, 23, 0, 59, 0, 0);
        set = 1'b1;
        cyc("w_to_min", S_MINUTE, 23, 0, 59, 0, 0);
        set = 1'b0;
        down = 1'b1;
        cyc("w_m_dn", S_MINUTE, 23, 59, 59, 0, 0);
        down = 1'b0;
        cyc("w_m_rel", S_MINUTE, 23, 59, 59, 0, 0);
        set = 1'b1;
        cyc("w_to_sec", S_SECOND, 23, 59, 59, 0, 0);
        set = 1'b0;
        up = 1'b1;
        cyc("w_s_up", S_SECOND, 23, 59, 0, 0, 0);
        up = 1'b0;
        cyc("w_s_rel", S_SECOND, 23, 59, 0, 0, 0);
        set = 1'b1;
        cyc("w_commit", S_IDLE, 23, 59, 0, 1, 0);
        set = 1'b0;
        cyc("w_idle", S_IDLE, 23, 59, 0, 0, 0);

        // Auto-repeat on a held up button in MINUTE
        cur_hours = 5'd10; cur_minutes = 6'd10; cur_seconds = 6'd0;
        set = 1'b1;
        cyc("r_load", S_HOUR, 10, 10, 0, 0, 0);
        cyc("r_to_min", S_MINUTE, 10, 10, 0, 0, 0);
        set = 1'b0;
        m_exp = 10;
        up = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k == 0 || (k >= D && (k - D) % P == 0)) m_exp++;
            cyc($sformatf("rep_%0d", k), S_MINUTE, 10, 6'(m_exp), 0, 0, 0);
        end
        up = 1'b0;
        cyc("rep_rel", S_MINUTE, 10, 15, 0, 0, 0);

        // Both held: nothing moves; survivor stays silent until re-pressed
        up = 1'b1; down = 1'b1;
        for (int k = 0; k < 5; k++) cyc($sformatf("both_%0d", k), S_MINUTE, 10, 15, 0, 0, 0);
        down = 1'b0;
        for (int k = 0; k < 6; k++) cyc($sformatf("survivor_%0d", k), S_MINUTE, 10, 15, 0, 0, 0);
        up = 1'b0;
        cyc("survivor_rel", S_MINUTE, 10, 15, 0, 0, 0);
        up = 1'b1;
        cyc("repress", S_MINUTE, 10, 16, 0, 0, 0);
        up = 1'b0;
        cyc("repress_rel", S_MINUTE, 10, 16, 0, 0, 0);

        // set together with up: field advances, no step, held button stays silent
        cur_hours = 5'd5; cur_minutes = 6'd7; cur_seconds = 6'd8;
        set = 1'b1;
        cyc("su_to_sec", S_SECOND, 10, 16, 0, 0, 0);
        cyc("su_commit", S_IDLE, 10, 16, 0, 1, 0);
        cyc("su_load", S_HOUR, 5, 7, 8, 0, 0);
        up = 1'b1;
        cyc("set_up", S_MINUTE, 5, 7, 8, 0, 0);
        set = 1'b0;
        for (int k = 0; k < 6; k++) cyc($sformatf("held_new_%0d", k), S_MINUTE, 5, 7, 8, 0, 0);
        up = 1'b0;
        cyc("held_rel", S_MINUTE, 5, 7, 8, 0, 0);

        // Timeout: counter advances every other cycle, so abort lands 2*T edges after entry
        set = 1'b1;
        cyc("t_to_sec", S_SECOND, 5, 7, 8, 0, 0);
        cyc("t_commit", S_IDLE, 5, 7, 8, 1, 0);
        cyc("t_enter", S_HOUR, 5, 7, 8, 0, 0);
        set = 1'b0;
        for (int k = 1; k < 2 * T - 1; k++) cyc($sformatf("t_wait_%0d", k), S_HOUR, 5, 7, 8, 0, 0);
        down = 1'b1;
        cyc("t_press", S_HOUR, 4, 7, 8, 0, 0);
        down = 1'b0;
        for (int k = 1; k < 2 * T; k++) cyc($sformatf("t_rewait_%0d", k), S_HOUR, 4, 7, 8, 0, 0);
        cyc("t_abort", S_IDLE, 4, 7, 8, 0, 1);
        cyc("t_after", S_IDLE, 4, 7, 8, 0, 0);

        // Out-of-range live values load as zero
        cur_hours = 5'd24; cur_minutes = 6'd33; cur_seconds = 6'd60;
        set = 1'b1;
        cyc("oor_load", S_HOUR, 0, 33, 0, 0, 0);
        cyc("oor_min", S_MINUTE, 0, 33, 0, 0, 0);
        set = 1'b0;

        // Asynchronous reset between edges mid-MINUTE
        @(negedge clk);
        reset = 1'b0;
        #1;
        push("async_rst", S_IDLE, 0, 0, 0, 0, 0);
        pop_compare();
        cyc("rst_held", S_IDLE, 0, 0, 0, 0, 0);
        reset = 1'b1;
        cyc("post_rst", S_IDLE, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
